// File: rtl/bosconian_video_timing_if.sv
// Raster timing bundle between the timing generator (slave) and its consumers (master).
// BOSCONIAN_SYNC_ADJ_EN adds the signed sync-position trims h_adj/v_adj.
interface bosconian_video_timing_if;
  logic       pal;
  logic       ce_pix;
  logic [8:0] hcount;
  logic [8:0] vcount;
  logic       HBlank;
  logic       VBlank;
  logic       HSync;
  logic       VSync;
  logic       frame_start;
  logic       pal_active;
`ifdef BOSCONIAN_SYNC_ADJ_EN
  logic [3:0] h_adj;
  logic [3:0] v_adj;

  modport slave  (input  pal, h_adj, v_adj,
                  output ce_pix, hcount, vcount, HBlank, VBlank, HSync, VSync,
                         frame_start, pal_active);
  modport master (output pal, h_adj, v_adj,
                  input  ce_pix, hcount, vcount, HBlank, VBlank, HSync, VSync,
                         frame_start, pal_active);
`else
  modport slave  (input  pal,
                  output ce_pix, hcount, vcount, HBlank, VBlank, HSync, VSync,
                         frame_start, pal_active);
  modport master (output pal,
                  input  ce_pix, hcount, vcount, HBlank, VBlank, HSync, VSync,
                         frame_start, pal_active);
`endif
endinterface

// File: rtl/bosconian_video_timing.sv
// Bosconian raster timing: pixel enable, h/v counters, blanking, sync, frame strobe, NTSC/PAL height.
// Optional BOSCONIAN_SYNC_ADJ_EN: per-frame signed trim of HSync/VSync start positions.
module bosconian_video_timing #(
  parameter int CE_DIV        = 8,
  parameter int H_TOTAL       = 384,
  parameter int H_ACTIVE      = 288,
  parameter int HS_START      = 304,
  parameter int HS_WIDTH      = 32,
  parameter int V_ACTIVE      = 224,
  parameter int V_TOTAL_NTSC  = 264,
  parameter int V_TOTAL_PAL   = 312,
  parameter int VS_START_NTSC = 240,
  parameter int VS_START_PAL  = 264,
  parameter int VS_WIDTH      = 3
) (
  input  logic                       clk,
  input  logic                       reset_n,
  bosconian_video_timing_if.slave    vid
);

  localparam int DW = (CE_DIV > 2) ? $clog2(CE_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CE_DIV - 1);
  localparam logic [8:0] H_LAST  = 9'(H_TOTAL - 1);
  localparam logic [8:0] H_ACT   = 9'(H_ACTIVE);
  localparam logic [8:0] V_ACT   = 9'(V_ACTIVE);
  localparam logic [8:0] VN_LAST = 9'(V_TOTAL_NTSC - 1);
  localparam logic [8:0] VP_LAST = 9'(V_TOTAL_PAL - 1);
  localparam logic [9:0] HS_LO   = 10'(HS_START);
  localparam logic [9:0] HS_LEN  = 10'(HS_WIDTH - 1);
  localparam logic [9:0] VSN_LO  = 10'(VS_START_NTSC);
  localparam logic [9:0] VSP_LO  = 10'(VS_START_PAL);
  localparam logic [9:0] VS_LEN  = 10'(VS_WIDTH - 1);

  logic [DW-1:0] div_q;
  logic          pal_s1_q, pal_s2_q, pal_act_q, pal_act_d;
  logic [8:0]    h_q, h_d, v_q, v_d;
  logic          ce_q, hb_q, vb_q, hs_q, vs_q, fs_q;
  logic          hb_d, vb_d, hs_d, vs_d, fs_d;
  logic          adv, line_wrap, frame_wrap;
  logic [9:0]    hs_lo, hs_hi, vs_lo, vs_hi;

`ifdef BOSCONIAN_SYNC_ADJ_EN
  logic [3:0] h_adj_q, h_adj_d, v_adj_q, v_adj_d;
`endif

  always_comb begin
    adv        = (div_q == DIV_LAST);
    line_wrap  = adv && (h_q == H_LAST);
    frame_wrap = line_wrap && (v_q == (pal_act_q ? VP_LAST : VN_LAST));
    h_d        = adv ? ((h_q == H_LAST) ? 9'd0 : h_q + 9'd1) : h_q;
    v_d        = frame_wrap ? 9'd0 : (line_wrap ? v_q + 9'd1 : v_q);
    // Frame height and sync placement are only allowed to change at the frame boundary.
    pal_act_d  = frame_wrap ? pal_s2_q : pal_act_q;
`ifdef BOSCONIAN_SYNC_ADJ_EN
    h_adj_d    = frame_wrap ? vid.h_adj : h_adj_q;
    v_adj_d    = frame_wrap ? vid.v_adj : v_adj_q;
    hs_lo      = HS_LO + {{6{h_adj_d[3]}}, h_adj_d};
    vs_lo      = (pal_act_d ? VSP_LO : VSN_LO) + {{6{v_adj_d[3]}}, v_adj_d};
`else
    hs_lo      = HS_LO;
    vs_lo      = pal_act_d ? VSP_LO : VSN_LO;
`endif
    hs_hi      = hs_lo + HS_LEN;
    vs_hi      = vs_lo + VS_LEN;
    // Decode from next-state counts so flags land on the same edge as the counters.
    hb_d       = (h_d >= H_ACT);
    vb_d       = (v_d >= V_ACT);
    hs_d       = ({1'b0, h_d} >= hs_lo) && ({1'b0, h_d} <= hs_hi);
    vs_d       = ({1'b0, v_d} >= vs_lo) && ({1'b0, v_d} <= vs_hi);
    fs_d       = adv && (h_d == 9'd0) && (v_d == 9'd0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q     <= '0;
      pal_s1_q  <= 1'b0;
      pal_s2_q  <= 1'b0;
      pal_act_q <= 1'b0;
      h_q       <= '0;
      v_q       <= '0;
      ce_q      <= 1'b0;
      hb_q      <= 1'b0;
      vb_q      <= 1'b0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      div_q     <= adv ? '0 : div_q + DW'(1);
      pal_s1_q  <= vid.pal;
      pal_s2_q  <= pal_s1_q;
      pal_act_q <= pal_act_d;
      ce_q      <= adv;
      fs_q      <= fs_d;
      if (adv) begin
        h_q  <= h_d;
        v_q  <= v_d;
        hb_q <= hb_d;
        vb_q <= vb_d;
        hs_q <= hs_d;
        vs_q <= vs_d;
      end
    end
  end

`ifdef BOSCONIAN_SYNC_ADJ_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_adj_q <= '0;
      v_adj_q <= '0;
    end else begin
      h_adj_q <= h_adj_d;
      v_adj_q <= v_adj_d;
    end
  end
`endif

  assign vid.ce_pix      = ce_q;
  assign vid.hcount      = h_q;
  assign vid.vcount      = v_q;
  assign vid.HBlank      = hb_q;
  assign vid.VBlank      = vb_q;
  assign vid.HSync       = hs_q;
  assign vid.VSync       = vs_q;
  assign vid.frame_start = fs_q;
  assign vid.pal_active  = pal_act_q;

endmodule

// File: tb/tb_bosconian_video_timing.sv
// Bench for bosconian_video_timing on a scaled raster (24x14 NTSC / 24x17 PAL, CE_DIV=8),
// with a cycle-count reference model running alongside directed and table checks.
module tb_bosconian_video_timing;
  localparam int CE_DIV = 8, H_TOTAL = 24, H_ACTIVE = 18, HS_START = 19, HS_WIDTH = 4;
  localparam int V_ACTIVE = 10, V_NTSC = 14, V_PAL = 17, VS_NTSC = 11, VS_PAL = 13, VS_WIDTH = 3;

  logic clk = 1'b0;
  logic reset_n;
  logic pal;
  always #5 clk = ~clk;

  bosconian_video_timing_if vid();
  assign vid.pal = pal;
`ifdef BOSCONIAN_SYNC_ADJ_EN
  assign vid.h_adj = 4'd0;
  assign vid.v_adj = 4'd0;
`endif

  bosconian_video_timing #(
    .CE_DIV(CE_DIV), .H_TOTAL(H_TOTAL), .H_ACTIVE(H_ACTIVE), .HS_START(HS_START),
    .HS_WIDTH(HS_WIDTH), .V_ACTIVE(V_ACTIVE), .V_TOTAL_NTSC(V_NTSC), .V_TOTAL_PAL(V_PAL),
    .VS_START_NTSC(VS_NTSC), .VS_START_PAL(VS_PAL), .VS_WIDTH(VS_WIDTH)
  ) dut (.clk(clk), .reset_n(reset_n), .vid(vid));

  int n_tests = 0, n_fail = 0, model_prints = 0;
  bit chk_en = 1'b0;

  // Reference model: raster position derived from clocks since reset release.
  int m_clk, m_fline;
  bit m_mode;

  function automatic int vt(bit m);
    return m ? V_PAL : V_NTSC;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_clk = 0; m_fline = 0; m_mode = 1'b0;
    end else begin
      m_clk++;
      if ((m_clk / CE_DIV) / H_TOTAL - m_fline == vt(m_mode)) begin
        m_fline += vt(m_mode);
        m_mode = pal;
      end
    end
  end

  always @(negedge clk) begin : model_check
    int n, e_h, e_v, vlo;
    bit e_ce;
    logic [24:0] act, exp;
    if (chk_en) begin
      n    = m_clk / CE_DIV;
      e_ce = (m_clk > 0) && (m_clk % CE_DIV == 0);
      e_h  = n % H_TOTAL;
      e_v  = n / H_TOTAL - m_fline;
      vlo  = m_mode ? VS_PAL : VS_NTSC;
      exp  = {e_ce, e_ce && e_h == 0 && e_v == 0, m_mode, e_h >= H_ACTIVE, e_v >= V_ACTIVE,
              e_h >= HS_START && e_h < HS_START + HS_WIDTH, e_v >= vlo && e_v < vlo + VS_WIDTH,
              9'(e_h), 9'(e_v)};
      act  = {vid.ce_pix, vid.frame_start, vid.pal_active, vid.HBlank, vid.VBlank,
              vid.HSync, vid.VSync, vid.hcount, vid.vcount};
      n_tests++;
      if (act !== exp) begin
        n_fail++;
        if (model_prints < 10) begin
          model_prints++;
          $display("FAIL model t=%0t got %h expected %h", $time, act, exp);
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int outs_vec();
    return int'({vid.ce_pix, vid.frame_start, vid.pal_active, vid.HBlank, vid.VBlank,
                 vid.HSync, vid.VSync, vid.hcount, vid.vcount});
  endfunction

  task automatic wait_pix(input int h, input int v, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (vid.ce_pix && int'(vid.hcount) == h && int'(vid.vcount) == v) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  // Counts ce_pix pulses up to and including the next frame_start; also tracks VSync lines.
  task automatic run_frame(output int pix, output int vs_lo, output int vs_hi, output int vmax);
    pix = 0; vs_lo = 999; vs_hi = -1; vmax = 0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (vid.ce_pix) begin
        pix++;
        if (vid.VSync && int'(vid.vcount) < vs_lo) vs_lo = int'(vid.vcount);
        if (vid.VSync && int'(vid.vcount) > vs_hi) vs_hi = int'(vid.vcount);
        if (int'(vid.vcount) > vmax) vmax = int'(vid.vcount);
        if (vid.frame_start) return;
      end
    end
    pix = -1;
  endtask

  typedef struct {
    int h; int v;
    bit hb; bit vb; bit hs; bit vs; bit fs;
  } vec_t;
  vec_t tbl[12];

  initial begin
    bit ok;
    int pix, vlo, vhi, vmax, cnt;

    tbl[0]  = '{1,  0,  0, 0, 0, 0, 0};
    tbl[1]  = '{17, 0,  0, 0, 0, 0, 0};
    tbl[2]  = '{18, 0,  1, 0, 0, 0, 0};
    tbl[3]  = '{19, 0,  1, 0, 1, 0, 0};
    tbl[4]  = '{22, 0,  1, 0, 1, 0, 0};
    tbl[5]  = '{23, 0,  1, 0, 0, 0, 0};
    tbl[6]  = '{0,  1,  0, 0, 0, 0, 0};
    tbl[7]  = '{0,  10, 0, 1, 0, 0, 0};
    tbl[8]  = '{0,  11, 0, 1, 0, 1, 0};
    tbl[9]  = '{20, 13, 1, 1, 1, 1, 0};
    tbl[10] = '{23, 13, 1, 1, 0, 1, 0};
    tbl[11] = '{0,  0,  0, 0, 0, 0, 1};

    pal = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    repeat (18) @(negedge clk);
    chk("reset_outs", outs_vec(), 0);
    reset_n = 1'b1;

    // First pixel enable lands on the 8th clock after release, with hcount already 1.
    for (int k = 1; k <= CE_DIV; k++) begin
      @(negedge clk);
      chk($sformatf("first_ce_k%0d", k), int'(vid.ce_pix), (k == CE_DIV) ? 1 : 0);
    end
    chk("first_hcount", int'(vid.hcount), 1);
    chk("first_vcount", int'(vid.vcount), 0);

    for (int i = 0; i < 12; i++) begin
      wait_pix(tbl[i].h, tbl[i].v, ok);
      chk($sformatf("tbl%0d_reached", i), int'(ok), 1);
      if (ok)
        chk($sformatf("tbl%0d_flags", i),
            int'({vid.HBlank, vid.VBlank, vid.HSync, vid.VSync, vid.frame_start}),
            int'({tbl[i].hb, tbl[i].vb, tbl[i].hs, tbl[i].vs, tbl[i].fs}));
    end

    run_frame(pix, vlo, vhi, vmax);
    chk("ntsc_frame_pix", pix, H_TOTAL * V_NTSC);
    chk("ntsc_vs_first", vlo, VS_NTSC);
    chk("ntsc_vs_last", vhi, VS_NTSC + VS_WIDTH - 1);
    chk("ntsc_vmax", vmax, V_NTSC - 1);
    chk("ntsc_pal_active", int'(vid.pal_active), 0);

    wait_pix(0, 2, ok);
    chk("line_start_reached", int'(ok), 1);
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (vid.ce_pix) cnt++;
      if (vid.ce_pix && vid.hcount == 9'd0) break;
    end
    chk("line_pix", cnt, H_TOTAL);
    chk("line_vcount", int'(vid.vcount), 3);

    // Mid-frame switch to PAL must not stretch the frame already in progress.
    wait_pix(0, 5, ok);
    chk("pal_switch_reached", int'(ok), 1);
    pal = 1'b1;
    run_frame(pix, vlo, vhi, vmax);
    chk("ntsc_tail_pix", pix, H_TOTAL * (V_NTSC - 5));
    chk("pal_active_set", int'(vid.pal_active), 1);
    run_frame(pix, vlo, vhi, vmax);
    chk("pal_frame_pix", pix, H_TOTAL * V_PAL);
    chk("pal_vs_first", vlo, VS_PAL);
    chk("pal_vs_last", vhi, VS_PAL + VS_WIDTH - 1);
    chk("pal_vmax", vmax, V_PAL - 1);
    chk("pal_active_hold", int'(vid.pal_active), 1);
    pal = 1'b0;
    run_frame(pix, vlo, vhi, vmax);
    chk("pal_frame2_pix", pix, H_TOTAL * V_PAL);
    chk("pal_active_clear", int'(vid.pal_active), 0);

    for (int i = 0; i < 8; i++) begin
      wait_pix(int'($urandom_range(0, H_TOTAL - 1)), int'($urandom_range(2, 9)), ok);
      chk($sformatf("rand%0d_reached", i), int'(ok), 1);
      pal = 1'($urandom_range(0, 1));
    end

    pal = 1'b0;
    wait_pix(13, 7, ok);
    chk("mid_reset_reached", int'(ok), 1);
    #2 reset_n = 1'b0;
    #1 chk("mid_reset_outs", outs_vec(), 0);
    repeat (3) @(negedge clk);
    chk("mid_reset_hold", outs_vec(), 0);
    reset_n = 1'b1;
    run_frame(pix, vlo, vhi, vmax);
    chk("post_reset_frame_pix", pix, H_TOTAL * V_NTSC);
    chk("post_reset_pal_active", int'(vid.pal_active), 0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/bosconian_video_timing.md
Name: bosconian_video_timing

Overview:
- Raster timing generator upstream of bosconian_top's video pipeline.
- Divides the system clock into a pixel enable and produces horizontal/vertical counters, blanking, sync and a frame-start strobe.
- bosconian_top's tilemap/sprite/starfield logic consumes these; HBlank/HSync/VBlank/VSync/ce_pix pass through to the emu-level video outputs.
- Supports NTSC (264 lines) and PAL (312 lines) frame heights, selected by the OSD TV-mode bit.

Parameters:
- CE_DIV, 8, clk cycles per pixel (48 MHz -> 6 MHz)
- H_TOTAL, 384, pixels per line
- H_ACTIVE, 288, visible pixels per line
- HS_START, 304, hcount at which HSync asserts
- HS_WIDTH, 32, HSync length in pixels
- V_ACTIVE, 224, visible lines
- V_TOTAL_NTSC, 264, lines per NTSC frame
- V_TOTAL_PAL, 312, lines per PAL frame
- VS_START_NTSC, 240, vcount at which VSync asserts (NTSC)
- VS_START_PAL, 264, vcount at which VSync asserts (PAL)
- VS_WIDTH, 3, VSync length in lines

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- pal  in  1  requested mode, 0=NTSC 1=PAL; asynchronous to the frame
- ce_pix  out  1  one-clk pixel enable pulse
- hcount  out  9  pixel column, 0..H_TOTAL-1
- vcount  out  9  line, 0..active V_TOTAL-1
- HBlank  out  1  high when hcount >= H_ACTIVE
- VBlank  out  1  high when vcount >= V_ACTIVE
- HSync  out  1  active-high horizontal sync
- VSync  out  1  active-high vertical sync
- frame_start  out  1  one-clk pulse coincident with the ce_pix of pixel (0,0)
- pal_active  out  1  mode in force for the current frame

Behaviour:
- Reset (reset_n low, async): divider=0; all outputs 0; pal_active=0 (NTSC).
- Divider counts 0..CE_DIV-1. On the clk edge where divider==CE_DIV-1, the divider wraps and the counters advance.
- ce_pix is registered high for exactly the clk cycle following that edge. Downstream logic sampling on ce_pix sees the new counts, which are stable for CE_DIV cycles.
- The first ce_pix after reset release occurs in cycle CE_DIV (1-based), with hcount=1.
- hcount increments per advance. At H_TOTAL-1 it wraps to 0 and vcount increments.
- vcount wraps to 0 after V_TOTAL-1, where V_TOTAL = pal_active ? V_TOTAL_PAL : V_TOTAL_NTSC.
- pal is double-flop synchronised. pal_active loads the synchronised value only on the advance that wraps vcount to 0; a mid-frame change never alters the current frame's height.
- HBlank, VBlank, HSync and VSync are registered from the next-state counter values, so they change on the same edge as hcount/vcount. They are never one pixel skewed from the counters.
- HSync = hcount in [HS_START, HS_START+HS_WIDTH-1].
- VSync = vcount in [VS_START, VS_START+VS_WIDTH-1], with VS_START taken from pal_active. VSync changes only at hcount==0 transitions.
- frame_start is high in the cycle where ce_pix is high and hcount==0, vcount==0.
- Outputs hold their values between advances; no glitches.
- Reset mid-frame returns everything to reset values immediately. Counting restarts from divider 0 after release.

Optional Feature:
- Macro BOSCONIAN_SYNC_ADJ_EN.
- When defined, adds inputs h_adj (4-bit signed) and v_adj (4-bit signed).
- Effective HS_START = HS_START+h_adj; effective VS_START = VS_START+v_adj.
- The adjust values are sampled into shadow registers at frame wrap, so no mid-frame shift occurs.
- Blanking and counters are unaffected.
- When undefined, the ports are absent and sync positions are fixed by parameters.

Test Plan:
- Reset held 20 clks, then released -> all outputs 0; first ce_pix in cycle 8 after release; ce_pix then every 8 clks, 1 clk wide.
- Run 384 pixels -> hcount 0..383 then 0; vcount increments once; HBlank high for hcount 288..383; HSync high for hcount 304..335 only.
- pal=0 for a full frame -> 264 lines (101376 pixels) between frame_start pulses; VBlank high for lines 224..263; VSync on lines 240..242.
- Toggle pal 0->1 at vcount=100 -> current frame still ends at line 263; pal_active=1 at the next frame_start; next frame is 312 lines with VSync on lines 264..266.
- Assert reset_n low at vcount=150, hcount=200 -> outputs 0 asynchronously; after release the first frame_start arrives after a full 264-line frame.
- With BOSCONIAN_SYNC_ADJ_EN, h_adj=-4 and v_adj=+2 applied mid-frame -> unchanged until the next frame; then HSync spans 300..331 and VSync spans lines 242..244 (NTSC).
